coreahblite_master_dataphase: RTL and testbench

- Per-master address decode and data-phase tracker for the AHB-Lite matrix.
- Decodes each master address phase into one of 16 slave slots, or the default slave.
- Registers the decode into a data-phase select and drives DEFSLAVEDATASEL to the default-slave state machine.
- Returns HRDATA/HREADY/HRESP to the master from either the selected slave or the default-slave responses.

---
 rtl/coreahblite_master_dataphase.sv | 145 ++++++++++++++
 tb/tb_coreahblite_master_dataphase.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coreahblite_master_dataphase.sv
// Per-master AHB-Lite address decode and data-phase tracker: routes responses from the selected slot or the default slave.
// Optional wait-state timeout enabled by defining COREAHBLITE_DATAPHASE_TIMEOUT_EN.
module coreahblite_master_dataphase #(
  parameter logic [15:0] SLAVE_EN       = 16'hFFFF,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic          HCLK,
  input  logic          HRESETN,
  input  logic [31:0]   HADDR_M,
  input  logic [1:0]    HTRANS_M,
  output logic          HREADY_M,
  output logic          HRESP_M,
  output logic [31:0]   HRDATA_M,
  output logic [15:0]   HSEL_S,
  input  logic [511:0]  HRDATA_S,
  input  logic [15:0]   HREADYOUT_S,
  input  logic [15:0]   HRESP_S,
  output logic          DEFSLAVEDATASEL,
  input  logic          DEFSLAVEDATAREADY,
  input  logic          HRESP_DEFAULT
);

`ifdef COREAHBLITE_DATAPHASE_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLAVE,
    ST_DEFAULT,
    ST_TOERR1,
    ST_TOERR2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLAVE,
    ST_DEFAULT
  } state_t;
`endif

  state_t      state_reg, state_next;
  logic [3:0]  data_sel_reg, data_sel_next;
  logic [3:0]  addr_slot;
  logic        slot_populated;
  logic        hready_int;
  logic [31:0] slave_rdata [16];

  // Reject out-of-range timeout limits at elaboration time.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  assign addr_slot      = HADDR_M[31:28];
  assign slot_populated = SLAVE_EN[addr_slot];

  for (genvar gi = 0; gi < 16; gi++) begin : g_slot
    assign HSEL_S[gi]      = (addr_slot == 4'(gi)) && SLAVE_EN[gi];
    assign slave_rdata[gi] = HRDATA_S[32*gi +: 32];
  end

`ifdef COREAHBLITE_DATAPHASE_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] to_cnt_reg, to_cnt_next;
`endif

  always_comb begin
    state_next      = state_reg;
    data_sel_next   = data_sel_reg;
    hready_int      = 1'b1;
    HRESP_M         = 1'b0;
    HRDATA_M        = 32'h0;
    DEFSLAVEDATASEL = 1'b0;

    case (state_reg)
      ST_SLAVE: begin
        hready_int = HREADYOUT_S[data_sel_reg];
        HRESP_M    = HRESP_S[data_sel_reg];
        HRDATA_M   = slave_rdata[data_sel_reg];
      end
      ST_DEFAULT: begin
        DEFSLAVEDATASEL = 1'b1;
        hready_int      = DEFSLAVEDATAREADY;
        HRESP_M         = HRESP_DEFAULT;
      end
`ifdef COREAHBLITE_DATAPHASE_TIMEOUT_EN
      ST_TOERR1: begin
        hready_int = 1'b0;
        HRESP_M    = 1'b1;
      end
      ST_TOERR2: begin
        HRESP_M = 1'b1;
      end
`endif
      default: ;
    endcase

    // The next address phase is captured in the same cycle the current data phase completes.
    if (hready_int) begin
      if (HTRANS_M[1] && slot_populated) begin
        state_next    = ST_SLAVE;
        data_sel_next = addr_slot;
      end else if (HTRANS_M[1]) begin
        state_next = ST_DEFAULT;
      end else begin
        state_next = ST_IDLE;
      end
    end

`ifdef COREAHBLITE_DATAPHASE_TIMEOUT_EN
    to_cnt_next = to_cnt_reg;
    if (hready_int) begin
      to_cnt_next = 8'h0;
    end else if (state_reg == ST_SLAVE) begin
      to_cnt_next = to_cnt_reg + 8'd1;
      if (to_cnt_reg + 8'd1 == TO_LIMIT) begin
        state_next = ST_TOERR1;
      end
    end
    if (state_reg == ST_TOERR1) begin
      state_next = ST_TOERR2;
    end
`endif
  end

  assign HREADY_M = hready_int;

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_reg    <= ST_IDLE;
      data_sel_reg <= 4'h0;
    end else begin
      state_reg    <= state_next;
      data_sel_reg <= data_sel_next;
    end
  end

`ifdef COREAHBLITE_DATAPHASE_TIMEOUT_EN
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      to_cnt_reg <= 8'h0;
    end else begin
      to_cnt_reg <= to_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_coreahblite_master_dataphase.sv
// Scoreboard bench for coreahblite_master_dataphase: slave and default-slave models, expected responses queued at address acceptance.
module tb_coreahblite_master_dataphase;

  localparam logic [15:0] EN = 16'h00FF;
  localparam int          TO = 4;

  logic          HCLK = 1'b0;
  logic          HRESETN;
  logic [31:0]   HADDR_M;
  logic [1:0]    HTRANS_M;
  logic          HREADY_M;
  logic          HRESP_M;
  logic [31:0]   HRDATA_M;
  logic [15:0]   HSEL_S;
  logic [511:0]  HRDATA_S;
  logic [15:0]   HREADYOUT_S;
  logic [15:0]   HRESP_S;
  logic          DEFSLAVEDATASEL;
  logic          DEFSLAVEDATAREADY;
  logic          HRESP_DEFAULT;

  coreahblite_master_dataphase #(.SLAVE_EN(EN), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK              (HCLK),
    .HRESETN           (HRESETN),
    .HADDR_M           (HADDR_M),
    .HTRANS_M          (HTRANS_M),
    .HREADY_M          (HREADY_M),
    .HRESP_M           (HRESP_M),
    .HRDATA_M          (HRDATA_M),
    .HSEL_S            (HSEL_S),
    .HRDATA_S          (HRDATA_S),
    .HREADYOUT_S       (HREADYOUT_S),
    .HRESP_S           (HRESP_S),
    .DEFSLAVEDATASEL   (DEFSLAVEDATASEL),
    .DEFSLAVEDATAREADY (DEFSLAVEDATAREADY),
    .HRESP_DEFAULT     (HRESP_DEFAULT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    int          waits;
    logic [31:0] data;
    bit          err;
  } xfer_t;

  typedef struct {
    logic [31:0] data;
    logic        resp;
    int          waits;
    logic        lw_resp;
  } exp_t;

  xfer_t stim_q[$];
  exp_t  exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  bit          ph_act = 0;
  bit          ph_map;
  int          ph_slot;
  int          ph_rem;
  logic [31:0] ph_data;
  bit          ph_err;
  int          ph_cnt;
  logic        prev_resp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_hsel(input logic [31:0] a);
    logic [15:0] r;
    r = '0;
    if (EN[a[31:28]]) r[a[31:28]] = 1'b1;
    return r;
  endfunction

  task automatic push(input logic [31:0] a, input int w, input logic [31:0] d, input bit e);
    xfer_t t;
    t.addr = a; t.waits = w; t.data = d; t.err = e;
    stim_q.push_back(t);
  endtask

  task automatic start_phase();
    xfer_t t;
    exp_t  e;
    t       = stim_q.pop_front();
    ph_act  = 1;
    ph_cnt  = 0;
    ph_slot = int'(t.addr[31:28]);
    ph_map  = EN[ph_slot];
    ph_rem  = ph_map ? t.waits : 1;
    ph_data = t.data;
    ph_err  = t.err;
    if (!ph_map) begin
      e.data = 32'h0; e.resp = 1'b1; e.waits = 1; e.lw_resp = 1'b1;
`ifdef COREAHBLITE_DATAPHASE_TIMEOUT_EN
    end else if (t.waits >= TO) begin
      e.data = 32'h0; e.resp = 1'b1; e.waits = TO + 1; e.lw_resp = 1'b1;
`endif
    end else begin
      e.data = t.data; e.resp = t.err; e.waits = t.waits; e.lw_resp = t.err;
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int budget, input bit allow_stall, output int cyc);
    logic rdy;
    exp_t e;
    cyc = 0;
    while ((stim_q.size() > 0 || ph_act) && cyc < budget) begin
      @(negedge HCLK);
      cyc++;
      HREADYOUT_S       = '1;
      HRESP_S           = '0;
      DEFSLAVEDATAREADY = 1'b1;
      HRESP_DEFAULT     = 1'b0;
      for (int s = 0; s < 16; s++) HRDATA_S[32*s +: 32] = 32'hBAD0_0000 | 32'(s);
      if (ph_act && ph_map) begin
        HREADYOUT_S[ph_slot] = (ph_rem == 0);
        HRESP_S[ph_slot]     = ph_err;
        if (ph_rem == 0) HRDATA_S[32*ph_slot +: 32] = ph_data;
      end
      if (ph_act && !ph_map) begin
        DEFSLAVEDATAREADY = (ph_rem == 0);
        HRESP_DEFAULT     = 1'b1;
      end
      if (stim_q.size() > 0) begin
        HADDR_M  = stim_q[0].addr;
        HTRANS_M = 2'b10;
      end else begin
        HTRANS_M = 2'b00;
      end
      #1;
      check("hsel", 32'(HSEL_S), 32'(exp_hsel(HADDR_M)));
      check("defsel", 32'(DEFSLAVEDATASEL), 32'(ph_act && !ph_map));
      if (!ph_act) begin
        check("idle_ready", 32'(HREADY_M), 32'd1);
        check("idle_resp", 32'(HRESP_M), 32'd0);
        check("idle_rdata", HRDATA_M, 32'h0);
      end else if (HREADY_M) begin
        if (exp_q.size() == 0) begin
          check("exp_queue_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("xfer slot %0d: rdata %h resp %0d waits %0d", ph_slot, HRDATA_M, HRESP_M, ph_cnt);
          check("rdata", HRDATA_M, e.data);
          check("resp", 32'(HRESP_M), 32'(e.resp));
          check("waits", 32'(ph_cnt), 32'(e.waits));
          if (e.waits > 0) check("wait_resp", 32'(prev_resp), 32'(e.lw_resp));
        end
      end else begin
        ph_cnt++;
        prev_resp = HRESP_M;
      end
      rdy = HREADY_M;
      @(posedge HCLK);
      if (rdy) begin
        ph_act = 0;
        if (HTRANS_M[1]) start_phase();
      end else if (ph_rem > 0) begin
        ph_rem--;
      end
    end
    if (!allow_stall && (stim_q.size() > 0 || ph_act)) begin
      check("cycle_budget", 32'(cyc), 32'(budget + 1));
    end
  endtask

  task automatic reset_mid_phase(input string tag);
    #3;
    HRESETN = 1'b0;
    #1;
    check({tag, "_ready"}, 32'(HREADY_M), 32'd1);
    check({tag, "_resp"}, 32'(HRESP_M), 32'd0);
    check({tag, "_rdata"}, HRDATA_M, 32'h0);
    check({tag, "_defsel"}, 32'(DEFSLAVEDATASEL), 32'd0);
    stim_q.delete();
    exp_q.delete();
    ph_act   = 0;
    HTRANS_M = 2'b00;
    @(negedge HCLK);
    HRESETN = 1'b1;
  endtask

  initial begin
    int cyc;
    HRESETN           = 1'b0;
    HADDR_M           = 32'h0;
    HTRANS_M          = 2'b00;
    HRDATA_S          = '0;
    HREADYOUT_S       = '1;
    HRESP_S           = '0;
    DEFSLAVEDATAREADY = 1'b1;
    HRESP_DEFAULT     = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETN = 1'b1;

    // Reset state and pure address decode with no transfer.
    @(negedge HCLK);
    check("rst_ready", 32'(HREADY_M), 32'd1);
    check("rst_resp", 32'(HRESP_M), 32'd0);
    check("rst_rdata", HRDATA_M, 32'h0);
    check("rst_defsel", 32'(DEFSLAVEDATASEL), 32'd0);
    HADDR_M = 32'h2000_0000; #1;
    check("hsel_slot2", 32'(HSEL_S), 32'h0004);
    HADDR_M = 32'h7000_0000; #1;
    check("hsel_slot7", 32'(HSEL_S), 32'h0080);
    HADDR_M = 32'h9000_0010; #1;
    check("hsel_unmapped", 32'(HSEL_S), 32'h0000);

    push(32'h2000_0000, 2, 32'hDEAD_BEEF, 0);
    run(50, 0, cyc);
    check("slot2_cycles", 32'(cyc), 32'd4);

    push(32'h9000_0010, 0, 32'h0, 0);
    run(50, 0, cyc);
    check("unmapped_cycles", 32'(cyc), 32'd3);

    push(32'h1000_0000, 1, 32'h1111_0000, 0);
    push(32'h9000_0000, 0, 32'h0, 0);
    push(32'h1000_0004, 0, 32'h1111_0004, 0);
    run(50, 0, cyc);
    check("b2b_cycles", 32'(cyc), 32'd6);

    push(32'h9000_0000, 0, 32'h0, 0);
    push(32'hA000_0000, 0, 32'h0, 0);
    run(50, 0, cyc);
    check("two_unmapped_cycles", 32'(cyc), 32'd5);

    push(32'h3000_0008, 1, 32'h3333_3333, 1);
    run(50, 0, cyc);

    push(32'h3000_0000, 1000, 32'h0, 0);
    run(4, 1, cyc);
    reset_mid_phase("rst_mid");
    push(32'h4000_0004, 0, 32'h4444_4444, 0);
    run(50, 0, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd2);

`ifdef COREAHBLITE_DATAPHASE_TIMEOUT_EN
    push(32'h5000_0000, 1000, 32'h5555_5555, 0);
    push(32'h6000_0000, 0, 32'h6666_6666, 0);
    run(50, 0, cyc);
`else
    push(32'h5000_0000, 1000, 32'h5555_5555, 0);
    run(100, 1, cyc);
    check("stall100_ready", 32'(HREADY_M), 32'd0);
    check("stall100_waits", 32'(ph_cnt), 32'd99);
    reset_mid_phase("rst_stall");
    push(32'h6000_0000, 0, 32'h6666_6666, 0);
    run(50, 0, cyc);
`endif

    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
